// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - MM:SS BCD stopwatch controller with IDLE/RUN/PAUSE states
//
// Purpose: counts 1 s ticks into four BCD digits (minutes wrap after
// MIN_LIMIT:59) under start/stop/clear command pulses.
// Optional feature macro: STOPWATCH_LAP_EN (adds i_lap and a display freeze).
//
// Ports:
//   clk                      sole clock, rising edge
//   sreset                   synchronous active-high reset
//   i_tick                   one-cycle count pulse (1 s prescaler)
//   i_start/i_stop/i_clear   single-cycle commands, priority clear > stop > start
//   i_lap                    (STOPWATCH_LAP_EN only) toggle lap freeze while running
//   o_sec_ones..o_min_tens   BCD display digits
//   o_running                high while in RUN
//   o_wrap                   one-cycle pulse when MIN_LIMIT:59 rolls to 00:00

module stopwatch_ctrl #(
  parameter int MIN_LIMIT = 59
) (
  input  logic       clk,
  input  logic       sreset,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       i_lap,
`endif
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_min_tens,
  output logic       o_running,
  output logic       o_wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);

  state_t      r_state;
  logic [3:0]  r_sec_ones;
  logic [3:0]  r_sec_tens;
  logic [3:0]  r_min_ones;
  logic [3:0]  r_min_tens;
  logic        r_wrap;

  logic [3:0]  w_sec_ones_nx;
  logic [3:0]  w_sec_tens_nx;
  logic [3:0]  w_min_ones_nx;
  logic [3:0]  w_min_tens_nx;
  logic        w_at_limit;
  logic        w_count;

  // Only counts in RUN; clear always wins over a coincident tick.
  assign w_count = (r_state == RUN) && i_tick && !i_clear;

  assign w_at_limit = (r_min_tens == LIM_TENS) && (r_min_ones == LIM_ONES) &&
                      (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);

  // BCD increment of the live count, with the minutes field wrapping
  // to 00 after MIN_LIMIT instead of running on to 99.
  always_comb begin
    w_sec_ones_nx = r_sec_ones;
    w_sec_tens_nx = r_sec_tens;
    w_min_ones_nx = r_min_ones;
    w_min_tens_nx = r_min_tens;
    if (r_sec_ones != 4'd9) begin
      w_sec_ones_nx = r_sec_ones + 4'd1;
    end else begin
      w_sec_ones_nx = 4'd0;
      if (r_sec_tens != 4'd5) begin
        w_sec_tens_nx = r_sec_tens + 4'd1;
      end else begin
        w_sec_tens_nx = 4'd0;
        if ((r_min_tens == LIM_TENS) && (r_min_ones == LIM_ONES)) begin
          w_min_ones_nx = 4'd0;
          w_min_tens_nx = 4'd0;
        end else if (r_min_ones == 4'd9) begin
          w_min_ones_nx = 4'd0;
          w_min_tens_nx = r_min_tens + 4'd1;
        end else begin
          w_min_ones_nx = r_min_ones + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state    <= IDLE;
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_clear) begin
        r_state    <= IDLE;
        r_sec_ones <= 4'd0;
        r_sec_tens <= 4'd0;
        r_min_ones <= 4'd0;
        r_min_tens <= 4'd0;
      end else begin
        if (w_count) begin
          r_sec_ones <= w_sec_ones_nx;
          r_sec_tens <= w_sec_tens_nx;
          r_min_ones <= w_min_ones_nx;
          r_min_tens <= w_min_tens_nx;
          r_wrap     <= w_at_limit;
        end
        // stop outranks start, so a coincident start is dropped.
        case (r_state)
          IDLE:    if (!i_stop && i_start) r_state <= RUN;
          RUN:     if (i_stop) r_state <= PAUSE;
          PAUSE:   if (!i_stop && i_start) r_state <= RUN;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_running = (r_state == RUN);
  assign o_wrap    = r_wrap;

`ifdef STOPWATCH_LAP_EN
  logic        r_freeze;
  logic [15:0] r_lap;

  // Snapshot is taken from the visible count at the lap edge; the live
  // count keeps advancing underneath while frozen.
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_freeze <= 1'b0;
      r_lap    <= 16'd0;
    end else if (i_clear || i_stop) begin
      r_freeze <= 1'b0;
    end else if ((r_state == RUN) && i_lap) begin
      r_freeze <= !r_freeze;
      if (!r_freeze) r_lap <= {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
    end
  end

  assign o_min_tens = r_freeze ? r_lap[15:12] : r_min_tens;
  assign o_min_ones = r_freeze ? r_lap[11:8]  : r_min_ones;
  assign o_sec_tens = r_freeze ? r_lap[7:4]   : r_sec_tens;
  assign o_sec_ones = r_freeze ? r_lap[3:0]   : r_sec_ones;
`else
  assign o_min_tens = r_min_tens;
  assign o_min_ones = r_min_ones;
  assign o_sec_tens = r_sec_tens;
  assign o_sec_ones = r_sec_ones;
`endif

endmodule
